// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------------------------
// sdram_port_arbiter : burst arbiter sharing one SDRAM controller between cam0/cam1 writers
// and one frame readout. Rev 1.0
// ------------------------------------------------------------------------------------------
module sdram_port_arbiter #(
  parameter logic [9:0]  BURST_LEN   = 10'd512,
  parameter logic [23:0] FRAME_WORDS = 24'h4B0000,
  parameter logic [23:0] CAM1_BASE   = 24'h4B0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        wr0_req,
  input  logic        wr1_req,
  input  logic        rd_req,
  input  logic        rd_urgent,
  input  logic        cmd_ready,
  input  logic        burst_done,
  output logic        cmd_valid,
  output logic        cmd_write,
  output logic [23:0] cmd_addr,
  output logic [9:0]  cmd_len,
  output logic [2:0]  grant,
  output logic        frame_done0,
  output logic        frame_done1,
  output logic        rd_frame_done
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_ARB     = 2'd1;
  localparam logic [1:0]  S_ISSUE   = 2'd2;
  localparam logic [1:0]  S_BUSY    = 2'd3;
  localparam logic [23:0] C_STEP    = {14'd0, BURST_LEN};
  localparam logic [23:0] C_WR0_END = FRAME_WORDS;
  localparam logic [23:0] C_WR1_END = CAM1_BASE + FRAME_WORDS;
  localparam logic [23:0] C_RD_END  = CAM1_BASE + FRAME_WORDS;

  logic [1:0]  state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  last_q, last_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        cmd_write_q, cmd_write_d;
  logic [23:0] cmd_addr_q, cmd_addr_d;
  logic [23:0] wr0_addr_q, wr0_addr_d;
  logic [23:0] wr1_addr_q, wr1_addr_d;
  logic [23:0] rd_addr_q, rd_addr_d;
  logic        fd0_q, fd0_d, fd1_q, fd1_d, fdr_q, fdr_d;

  logic [2:0]  w_win;
  logic [23:0] w_wr0_next, w_wr1_next, w_rd_next;

  assign w_wr0_next = wr0_addr_q + C_STEP;
  assign w_wr1_next = wr1_addr_q + C_STEP;
  assign w_rd_next  = rd_addr_q + C_STEP;

  // Round-robin scan starts just after the last granted requester (last_q, one-hot).
  always_comb begin
    w_win = 3'b000;
    if (rd_urgent && rd_req) begin
      w_win = 3'b100;
    end else begin
      case (last_q)
        3'b001: begin
          if (wr1_req)      w_win = 3'b010;
          else if (rd_req)  w_win = 3'b100;
          else if (wr0_req) w_win = 3'b001;
        end
        3'b010: begin
          if (rd_req)       w_win = 3'b100;
          else if (wr0_req) w_win = 3'b001;
          else if (wr1_req) w_win = 3'b010;
        end
        default: begin
          if (wr0_req)      w_win = 3'b001;
          else if (wr1_req) w_win = 3'b010;
          else if (rd_req)  w_win = 3'b100;
        end
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cmd_valid_d = cmd_valid_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    wr0_addr_d  = wr0_addr_q;
    wr1_addr_d  = wr1_addr_q;
    rd_addr_d   = rd_addr_q;
    fd0_d       = 1'b0;
    fd1_d       = 1'b0;
    fdr_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (init_done && (wr0_req || wr1_req || rd_req)) state_d = S_ARB;
      end
      S_ARB: begin
        if (init_done && (w_win != 3'b000)) begin
          grant_d     = w_win;
          last_d      = w_win;
          cmd_valid_d = 1'b1;
          cmd_write_d = ~w_win[2];
          cmd_addr_d  = w_win[0] ? wr0_addr_q : (w_win[1] ? wr1_addr_q : rd_addr_q);
          state_d     = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (burst_done) begin
          grant_d = 3'b000;
          state_d = S_IDLE;
          if (grant_q[0]) begin
            fd0_d      = (w_wr0_next == C_WR0_END);
            wr0_addr_d = fd0_d ? 24'd0 : w_wr0_next;
          end
          if (grant_q[1]) begin
            fd1_d      = (w_wr1_next == C_WR1_END);
            wr1_addr_d = fd1_d ? CAM1_BASE : w_wr1_next;
          end
          if (grant_q[2]) begin
            fdr_d     = (w_rd_next == C_RD_END);
            rd_addr_d = fdr_d ? 24'd0 : w_rd_next;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= 3'b000;
      last_q      <= 3'b100;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= 24'd0;
      wr0_addr_q  <= 24'd0;
      wr1_addr_q  <= CAM1_BASE;
      rd_addr_q   <= 24'd0;
      fd0_q       <= 1'b0;
      fd1_q       <= 1'b0;
      fdr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      wr0_addr_q  <= wr0_addr_d;
      wr1_addr_q  <= wr1_addr_d;
      rd_addr_q   <= rd_addr_d;
      fd0_q       <= fd0_d;
      fd1_q       <= fd1_d;
      fdr_q       <= fdr_d;
    end
  end

  assign cmd_valid     = cmd_valid_q;
  assign cmd_write     = cmd_write_q;
  assign cmd_addr      = cmd_addr_q;
  assign cmd_len       = BURST_LEN;
  assign grant         = grant_q;
  assign frame_done0   = fd0_q;
  assign frame_done1   = fd1_q;
  assign rd_frame_done = fdr_q;

endmodule
`default_nettype wire

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 10'd512: words per SDRAM burst, identical for all requesters.
REQ-002 SHALL have parameter FRAME_WORDS, default 24'h4B0000: words per camera frame region; an exact multiple of BURST_LEN.
REQ-003 SHALL have parameter CAM1_BASE, default 24'h4B0000: start address of the cam1 region; the cam0 region starts at 24'd0.
REQ-004 SHALL have port clk, input, 1: single clock (100 MHz SDRAM reference domain); all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port init_done, input, 1: SDRAM initialisation complete; no grant is issued while it is low.
REQ-007 SHALL have ports wr0_req and wr1_req, input, 1 each: the cam0/cam1 write FIFO holds at least BURST_LEN words.
REQ-008 SHALL have port rd_req, input, 1: the read FIFO has room for BURST_LEN words.
REQ-009 SHALL have port rd_urgent, input, 1: the read FIFO is nearly empty; rd is given absolute priority.
REQ-010 SHALL have port cmd_ready, input, 1: the SDRAM controller accepts the command presented.
REQ-011 SHALL have port burst_done, input, 1: one-cycle pulse when the accepted burst completes.
REQ-012 SHALL have port cmd_valid, output, 1: a command is presented.
REQ-013 SHALL have port cmd_write, output, 1: 1 = write, 0 = read.
REQ-014 SHALL have port cmd_addr, output, 24: burst start address.
REQ-015 SHALL have port cmd_len, output, 10: always equal to BURST_LEN.
REQ-016 SHALL have port grant, output, 3: one-hot {rd, wr1, wr0}; selects the FIFO muxing in the SDRAM top.
REQ-017 SHALL have ports frame_done0, frame_done1 and rd_frame_done, output, 1 each: one-cycle pulse when the respective address counter wraps.

Function
REQ-018 SHALL implement the FSM states IDLE, ARB, ISSUE and BUSY.
- IDLE -> ARB when init_done = 1 and any of wr0_req, wr1_req or rd_req is 1.
REQ-019 ARB SHALL last exactly one cycle, latch the winner into grant and the winner's address into cmd_addr, then go to ISSUE.
REQ-020 Arbitration in ARB SHALL give priority to rd if rd_urgent && rd_req; otherwise it SHALL be round-robin over wr0 -> wr1 -> rd, starting after the last granted requester.
REQ-021 The round-robin pointer SHALL update only when a grant is issued.
REQ-022 In ISSUE, cmd_valid SHALL be 1 and cmd_addr, cmd_write and grant SHALL be held stable until the cycle in which cmd_ready = 1; the FSM SHALL then go to BUSY and drop cmd_valid on the next cycle.
REQ-023 In BUSY, grant SHALL be held; on burst_done = 1 the FSM SHALL advance the granted requester's address and return to IDLE.
- Minimum arbitration gap between consecutive bursts: 2 cycles (IDLE, ARB).
REQ-024 Address advance SHALL add BURST_LEN to the granted requester's counter.
- If the result equals region start + FRAME_WORDS, the counter SHALL wrap to region start and the matching frame-done output SHALL pulse in the same cycle.
REQ-025 Address regions SHALL be as follows:
- wr0: [0, FRAME_WORDS).
- wr1: [CAM1_BASE, CAM1_BASE+FRAME_WORDS).
- rd: [0, CAM1_BASE+FRAME_WORDS), a contiguous readout of both frames.
REQ-026 Address arithmetic SHALL be 24-bit unsigned; no counter shall ever exceed its region end.
REQ-027 Requests that deassert after the grant (REQ-019) SHALL be ignored for that burst; the grant is never withdrawn mid-burst.
REQ-028 A burst_done received outside BUSY SHALL be ignored, and no address SHALL advance.
REQ-029 If init_done falls, the FSM SHALL finish any burst in progress, then remain in IDLE until init_done returns.
REQ-030 cmd_write SHALL be 1 for wr0/wr1 grants and 0 for rd grants.
REQ-031 grant SHALL be all-zero in IDLE and ARB-before-latch, and one-hot in ISSUE and BUSY.

Reset
REQ-032 While rst_n = 0, outputs SHALL take these values:
- state = IDLE.
- cmd_valid = 0, cmd_write = 0, cmd_addr = 0, cmd_len = BURST_LEN, grant = 3'b000.
- All frame-done outputs = 0.
- wr0/rd counters = 0, wr1 counter = CAM1_BASE.
- Round-robin pointer set so that wr0 has first priority.
REQ-033 Reset assertion mid-burst SHALL abort immediately with no address advance; the first grant after release SHALL restart at region bases.

Verification
REQ-034 Scenario: init_done = 0 with all requests high -> cmd_valid stays 0 for 100 cycles; after init_done rises, the first grant is 3'b001 with cmd_addr = 0 and cmd_write = 1.
REQ-035 Scenario: wr0, wr1 and rd requests held high, cmd_ready = 1, burst_done 20 cycles after accept -> grants go 001, 010, 100, 001, with cmd_addr sequence 0, 0x4B0000, 0, 0x200.
REQ-036 Scenario: rd_urgent = 1 and rd_req = 1 while wr0/wr1 are pending after a wr0 burst -> the next grant is 3'b100, not 3'b010.
REQ-037 Scenario: 9600 wr0 bursts -> the 9600th burst_done pulses frame_done0 once and the next wr0 cmd_addr = 0; the rd counter wraps at 0x960000 with an rd_frame_done pulse.
REQ-038 Scenario: cmd_ready held 0 for 50 cycles in ISSUE while requests toggle -> cmd_valid, cmd_addr and grant stay stable; the command is accepted on the first cmd_ready = 1.
REQ-039 Scenario: rst_n pulsed low during BUSY of a wr1 burst at address 0x4B0400 -> outputs return to reset values; after release the next wr1 cmd_addr = 0x4B0000.
